// File: rtl/fp_mant_multiplier_seq.sv
// Sequential shift-add mantissa multiplier for the FP32 multiply path.
// Produces the biased exponent sum and the raw 2*MANT_W-bit product.
module fp_mant_multiplier_seq #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W-1:0]      a_e,
  input  logic [MANT_W-1:0]     a_m,
  input  logic [EXP_W-1:0]      b_e,
  input  logic [MANT_W-1:0]     b_m,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W-1:0]      out_e,
  output logic [2*MANT_W-1:0]   out_m,
  output logic                  exp_ovf,
  output logic                  exp_unf
);

  localparam int CW = $clog2(MANT_W);
  localparam int PW = 2 * MANT_W;
  localparam int SW = EXP_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [MANT_W-1:0]    a_r;
  logic [MANT_W-1:0]    b_r;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        addend;
  logic [PW-1:0]        acc_nx;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 zero_op;
  logic                 last;
  logic signed [SW-1:0] s;

  assign accept  = in_valid & in_ready;
  assign zero_op = (a_m == '0) | (b_m == '0);
  assign last    = (cnt == CW'(MANT_W - 1));

  // Two extra bits: one for the carry of the sum, one for the sign.
  assign s = $signed(SW'(a_e) + SW'(b_e) - SW'(BIAS));

  assign addend = b_r[cnt] ? (PW'(a_r) << cnt) : '0;
  assign acc_nx = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = zero_op ? DONE : BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_m   <= '0;
      out_e   <= '0;
      exp_ovf <= 1'b0;
      exp_unf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= a_m;
            b_r     <= b_m;
            acc     <= '0;
            cnt     <= '0;
            out_e   <= s[EXP_W-1:0];
            exp_ovf <= ~s[SW-1] & s[EXP_W];
            exp_unf <= s[SW-1];
            if (zero_op) out_m <= '0;
          end
        end
        BUSY: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (last) out_m <= acc_nx;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_multiplier_seq.sv
// Directed bench for fp_mant_multiplier_seq.
// Hand-computed products, exponents, flags, latency and handshakes.
module tb_fp_mant_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_e;
  logic [23:0] a_m;
  logic [7:0]  b_e;
  logic [23:0] b_m;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_e;
  logic [47:0] out_m;
  logic        exp_ovf;
  logic        exp_unf;

  int errors = 0;
  int checks = 0;

  fp_mant_multiplier_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_e       (a_e),
    .a_m       (a_m),
    .b_e       (b_e),
    .b_m       (b_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_e     (out_e),
    .out_m     (out_m),
    .exp_ovf   (exp_ovf),
    .exp_unf   (exp_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] ae, input logic [23:0] am,
                        input logic [7:0] be, input logic [23:0] bm);
    check("acc_in_ready", 64'(in_ready), 64'd1);
    a_e = ae; a_m = am; b_e = be; b_m = bm;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a_e = 8'hxx; a_m = 24'h5A5A5A; b_e = 8'h33; b_m = 24'h123456;
  endtask

  task automatic wait_valid(input string tag, input int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n == 0) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [7:0] e,
                           input logic [47:0] m, input logic ovf,
                           input logic unf);
    check({tag, "_m"}, 64'(out_m), 64'(m));
    check({tag, "_e"}, 64'(out_e), 64'(e));
    check({tag, "_ovf"}, 64'(exp_ovf), 64'(ovf));
    check({tag, "_unf"}, 64'(exp_unf), 64'(unf));
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
    check({tag, "_novalid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op(input string tag, input logic [7:0] ae,
                    input logic [23:0] am, input logic [7:0] be,
                    input logic [23:0] bm, input int lat,
                    input logic [7:0] e, input logic [47:0] m,
                    input logic ovf, input logic unf);
    accept(ae, am, be, bm);
    wait_valid(tag, lat);
    check_res(tag, e, m, ovf, unf);
    release_out(tag);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_e = '0; a_m = '0; b_e = '0; b_m = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_m", 64'(out_m), 64'd0);
    check("rst_out_e", 64'(out_e), 64'd0);
    check("rst_ovf", 64'(exp_ovf), 64'd0);
    check("rst_unf", 64'(exp_unf), 64'd0);

    op("one", 8'd127, 24'h800000, 8'd127, 24'h800000, 24,
       8'd127, 48'h400000000000, 1'b0, 1'b0);
    op("max", 8'd127, 24'hFFFFFF, 8'd127, 24'hFFFFFF, 24,
       8'd127, 48'hFFFFFE000001, 1'b0, 1'b0);
    op("ovf", 8'd200, 24'hC00000, 8'd200, 24'hC00000, 24,
       8'd17, 48'h900000000000, 1'b1, 1'b0);
    op("unf", 8'd10, 24'h800000, 8'd20, 24'h800000, 24,
       8'd159, 48'h400000000000, 1'b0, 1'b1);
    op("small", 8'd255, 24'h000003, 8'd255, 24'h000005, 24,
       8'd127, 48'h00000000000F, 1'b1, 1'b0);
    op("emin", 8'd0, 24'h000001, 8'd0, 24'hFFFFFF, 24,
       8'd129, 48'h000000FFFFFF, 1'b0, 1'b1);
    op("zero_a", 8'd130, 24'h000000, 8'd127, 24'hABCDEF, 1,
       8'd130, 48'h0, 1'b0, 1'b0);
    op("zero_b", 8'd127, 24'h800000, 8'd128, 24'h000000, 1,
       8'd128, 48'h0, 1'b0, 1'b0);
    op("edge_e", 8'd191, 24'h800000, 8'd191, 24'h800000, 24,
       8'd255, 48'h400000000000, 1'b0, 1'b0);

    // backpressure: result must hold while downstream stalls
    accept(8'd128, 24'hA00000, 8'd126, 24'hC00000);
    wait_valid("bp", 24);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_m = 24'h111111; b_m = 24'h222222;
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check_res("bp_hold", 8'd127, 48'h780000000000, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    release_out("bp");

    // reset in the middle of a multiply discards it
    accept(8'd127, 24'hFFFFFF, 8'd127, 24'hFFFFFF);
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstb_valid", 64'(out_valid), 64'd0);
    check("rstb_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rstb_no_result", 64'(seen), 64'd0);
    op("after_rst", 8'd127, 24'h800001, 8'd127, 24'h000002, 24,
       8'd127, 48'h000001000002, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_mant_multiplier_seq.md
Name: fp_mant_multiplier_seq

Overview:
- Sequential shift-add multiplier for the FP32 multiply datapath. Produces the raw exponent/product pair consumed by multiplication_normaliser.
- Takes unpacked operands: biased exponents plus 24-bit mantissas with the hidden bit already inserted.
- Computes the biased exponent sum and the full 48-bit mantissa product, one multiplier bit per cycle.
- Valid/ready handshakes on both sides; one operation in flight at a time.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; product width is 2*MANT_W.
- EXP_W, 8, exponent width.
- BIAS, 127, exponent bias subtracted from the exponent sum.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a_e  input  EXP_W  operand A biased exponent.
- a_m  input  MANT_W  operand A mantissa.
- b_e  input  EXP_W  operand B biased exponent.
- b_m  input  MANT_W  operand B mantissa.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_e  output  EXP_W  (a_e + b_e - BIAS) mod 2^EXP_W.
- out_m  output  2*MANT_W  unsigned product a_m*b_m.
- exp_ovf  output  1  true exponent sum minus BIAS > 2^EXP_W-1.
- exp_unf  output  1  true exponent sum minus BIAS < 0.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge. Sets state IDLE and counter 0. Sets out_valid, out_e, out_m, exp_ovf and exp_unf to 0, and in_ready to 1. Reset overrides everything, including mid-operation: the in-flight operation is discarded and no result is produced.
- States: IDLE, BUSY, DONE.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Accept: a transfer occurs when in_valid & in_ready are high at a rising edge.
  - Registers the operands.
  - Computes the exponent in EXP_W+2 signed arithmetic: s = a_e + b_e - BIAS.
  - out_e = s[EXP_W-1:0]; exp_ovf = (s > 2^EXP_W-1); exp_unf = (s < 0).
  - Exponent and flags are registered at acceptance and held until the result handshake.
- Zero shortcut: if a_m == 0 or b_m == 0 at acceptance, go directly to DONE with out_m = 0. out_valid is seen 1 cycle after the accept edge. The exponent and flags are still computed as above.
- Otherwise go to BUSY with accumulator = 0 and counter = 0.
- BUSY, each edge:
  - If bit[counter] of the registered b_m is 1, add (a_m << counter) to the 2*MANT_W-bit accumulator. This never overflows.
  - counter increments.
  - On the edge where counter == MANT_W-1, go to DONE with out_m = final accumulator.
  - Latency: out_valid is first high MANT_W (24) cycles after the accept edge.
- DONE: out_m, out_e and the flags stay stable while out_valid & !out_ready (backpressure, unbounded hold). On an out_valid & out_ready edge, go to IDLE. New operands can be accepted at the earliest on the following edge.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- out_m and out_e are not normalised here; normalisation is done downstream.

Test Plan:
- 1.0 x 1.0: a_e=b_e=127, a_m=b_m=24'h800000 -> out_m=48'h400000000000, out_e=127, ovf=unf=0, out_valid 24 cycles after accept.
- Max mantissa: a_m=b_m=24'hFFFFFF, a_e=b_e=127 -> out_m=48'hFFFFFE000001, out_e=127.
- Exponent overflow and underflow:
  - a_e=b_e=200, a_m=b_m=24'hC00000 -> out_e=17, exp_ovf=1, out_m=48'h900000000000.
  - a_e=10, b_e=20 -> out_e=159, exp_unf=1.
- Zero operand: a_m=0, b_m=24'hABCDEF, a_e=130, b_e=127 -> out_valid 1 cycle after accept, out_m=0, out_e=130.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. Raising out_ready for 1 cycle -> IDLE, in_ready=1.
- Reset mid-BUSY: assert rst at cycle 10 of BUSY -> next edge out_valid=0, in_ready=1. A new operation after reset yields a correct product with no residue from the aborted one.
